// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter and its grant logic.
package memory_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Owner encoding doubles as the bit index into the one-hot grant vector.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/memory_arbiter_arb_grant.sv
// Combinational grant selection between fetch and load/store requesters.
// A lone request always wins; on a tie the requester named by i_favour wins.
module arb_grant
  import memory_arbiter_pkg::*;
(
  input  logic       i_fetch_req,
  input  logic       i_data_req,
  input  logic       i_favour,
  output logic [1:0] o_grant
);

  // One-hot grant: bit 0 = fetch, bit 1 = data
  always_comb begin
    o_grant = 2'b00;
    if (i_fetch_req && i_data_req) begin
      o_grant = (i_favour == OWN_DATA) ? 2'b10 : 2'b01;
    end else if (i_data_req) begin
      o_grant = 2'b10;
    end else if (i_fetch_req) begin
      o_grant = 2'b01;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port main memory arbiter for instruction fetch and load/store.
// One transaction at a time: accept in IDLE, hold address/control for MEM_LATENCY
// cycles in ACCESS, then a one-cycle response pulse in RESP.
// Optional: define MEMORY_ARBITER_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise data always beats fetch.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  output logic              fetchRspValid,
  output logic [DATA_W-1:0] fetchRspData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataReady,
  output logic              dataRspValid,
  output logic [DATA_W-1:0] dataRspData,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memReadEnable,
  output logic              memWriteEnable,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fetch_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic [1:0]        w_grant;
  logic              w_favour;
  logic              w_idle;
  logic              w_accept;
  logic              w_last;

  arb_grant u_arb_grant (
    .i_fetch_req (fetchReq),
    .i_data_req  (dataReq),
    .i_favour    (w_favour),
    .o_grant     (w_grant)
  );

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic r_rr_favour;

  // Favour whichever requester lost the most recent accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_favour <= OWN_FETCH;
    end else if (w_accept) begin
      r_rr_favour <= ~w_grant[1];
    end
  end

  assign w_favour = r_rr_favour;
`else
  assign w_favour = OWN_DATA;
`endif

  // Ready is gated by reset so nothing looks accepted while reset is held
  assign w_idle     = (r_state == ST_IDLE) && !reset;
  assign fetchReady = w_idle && w_grant[0];
  assign dataReady  = w_idle && w_grant[1];
  assign w_accept   = fetchReady || dataReady;
  assign w_last     = (r_cnt == '0);

  // Transaction FSM: latch request on accept, count latency, capture read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_owner       <= OWN_FETCH;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_fetch_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant[1];
            r_addr  <= w_grant[1] ? dataAddr : fetchAddr;
            r_we    <= w_grant[1] && dataWe;
            if (w_grant[1]) begin
              r_wdata <= dataWdata;
            end
            r_cnt   <= CNT_INIT;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_last) begin
            if (r_owner == OWN_DATA) begin
              r_data_rdata <= r_we ? '0 : memDataOut;
            end else begin
              r_fetch_rdata <= memDataOut;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side and response outputs decoded from registered state
  always_comb begin
    memAddress     = r_addr;
    memDataIn      = r_wdata;
    memReadEnable  = (r_state == ST_ACCESS) && !r_we;
    // Write only in the final ACCESS cycle so the memory sees exactly one write
    memWriteEnable = (r_state == ST_ACCESS) && r_we && w_last;
    fetchRspValid  = (r_state == ST_RESP) && (r_owner == OWN_FETCH);
    dataRspValid   = (r_state == ST_RESP) && (r_owner == OWN_DATA);
    fetchRspData   = r_fetch_rdata;
    dataRspData    = r_data_rdata;
    busy           = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter (MEM_LATENCY = 3).
// Transaction-level model predicts every output each cycle; directed tests
// add hand-computed literal expectations.
module tb_memory_arbiter;

  localparam int LAT = 3;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReq, fetchReady, fetchRspValid;
  logic [31:0] fetchAddr, fetchRspData;
  logic        dataReq, dataWe, dataReady, dataRspValid;
  logic [31:0] dataAddr, dataWdata, dataRspData;
  logic [31:0] memAddress, memDataIn, memDataOut;
  logic        memReadEnable, memWriteEnable, busy;

  memory_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_LATENCY (LAT)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .fetchReq       (fetchReq),
    .fetchAddr      (fetchAddr),
    .fetchReady     (fetchReady),
    .fetchRspValid  (fetchRspValid),
    .fetchRspData   (fetchRspData),
    .dataReq        (dataReq),
    .dataWe         (dataWe),
    .dataAddr       (dataAddr),
    .dataWdata      (dataWdata),
    .dataReady      (dataReady),
    .dataRspValid   (dataRspValid),
    .dataRspData    (dataRspData),
    .memAddress     (memAddress),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .memDataIn      (memDataIn),
    .memDataOut     (memDataOut),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, write applied during the enabled cycle
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  int          wr_count = 0;

  assign memDataOut = mem[memAddress[5:2]];

  always @(negedge clk) begin
    if (memWriteEnable) begin
      mem[memAddress[5:2]] <= memDataIn;
      wr_count             <= wr_count + 1;
    end
  end

  // Transaction model: m_age = -1 when idle, otherwise cycles since accept
  int          m_age;
  logic        m_owner, m_we, m_favour, m_win;
  logic [31:0] m_addr, m_wdata, m_frsp, m_drsp;

  assign m_win = (fetchReq && dataReq) ? m_favour : dataReq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_age    <= -1;
      m_owner  <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_frsp   <= '0;
      m_drsp   <= '0;
      m_favour <= RR ? 1'b0 : 1'b1;
    end else if (m_age < 0) begin
      if (fetchReq || dataReq) begin
        m_owner <= m_win;
        m_addr  <= m_win ? dataAddr : fetchAddr;
        m_we    <= m_win && dataWe;
        if (m_win) m_wdata <= dataWdata;
        if (RR) m_favour <= ~m_win;
        m_age   <= 1;
      end
    end else if (m_age <= LAT) begin
      if (m_age == LAT) begin
        if (m_we) begin
          ref_mem[m_addr[5:2]] <= m_wdata;
          m_drsp               <= '0;
        end else if (m_owner) begin
          m_drsp <= ref_mem[m_addr[5:2]];
        end else begin
          m_frsp <= ref_mem[m_addr[5:2]];
        end
      end
      m_age <= m_age + 1;
    end else begin
      m_age <= -1;
    end
  end

  logic e_idle, e_acc, e_rsp, e_wr;
  assign e_idle = (m_age < 0) && !reset;
  assign e_acc  = !reset && (m_age >= 1) && (m_age <= LAT);
  assign e_rsp  = !reset && (m_age == LAT + 1);
  assign e_wr   = e_acc && m_we && (m_age == LAT);

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("fetchReady",     fetchReady,     e_idle && fetchReq && !m_win);
    chk("dataReady",      dataReady,      e_idle && dataReq && m_win);
    chk("memReadEnable",  memReadEnable,  e_acc && !m_we);
    chk("memWriteEnable", memWriteEnable, e_wr);
    chk("memAddress",     memAddress,     m_addr);
    chk("fetchRspValid",  fetchRspValid,  e_rsp && !m_owner);
    chk("dataRspValid",   dataRspValid,   e_rsp && m_owner);
    chk("fetchRspData",   fetchRspData,   m_frsp);
    chk("dataRspData",    dataRspData,    m_drsp);
    chk("busy",           busy,           m_age >= 0);
    if (e_wr) chk("memDataIn", memDataIn, m_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one request, scramble inputs after accept, wait for the response
  task automatic do_txn(input bit isd, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int t_acc, output int t_rsp,
                        output logic [31:0] rdata);
    bit got;
    t_acc = 0;
    t_rsp = 0;
    rdata = '0;
    if (isd) begin
      dataReq = 1'b1; dataWe = we; dataAddr = addr; dataWdata = wdata;
    end else begin
      fetchReq = 1'b1; fetchAddr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (isd ? dataReady : fetchReady) begin
        got   = 1'b1;
        t_acc = cyc;
      end
    end
    chk("accept_seen", got, 1'b1);
    tick();
    fetchReq  = 1'b0;
    dataReq   = 1'b0;
    fetchAddr = addr ^ 32'h30;
    dataAddr  = addr ^ 32'h30;
    dataWdata = ~wdata;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (isd ? dataRspValid : fetchRspValid) begin
        got   = 1'b1;
        t_rsp = cyc;
        rdata = isd ? dataRspData : fetchRspData;
      end
    end
    chk("rsp_seen", got, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ta, tr, tb, w0;
    int          acc_t [3];
    int          n_acc;
    bit          got;
    logic [31:0] rd;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h1000_0000 + i * 32'h0101;
      ref_mem[i] = 32'h1000_0000 + i * 32'h0101;
    end
    mem[0]     = 32'h4422_1802;
    ref_mem[0] = 32'h4422_1802;

    reset = 1'b1;
    fetchReq = 1'b0; fetchAddr = '0;
    dataReq = 1'b0; dataWe = 1'b0; dataAddr = '0; dataWdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memAddress",   memAddress,   32'h0);
    chk("rst_fetchRspData", fetchRspData, 32'h0);
    chk("rst_busy",         busy,         1'b0);
    #2 reset = 1'b0;
    tick();

    // Fetch from address 0
    do_txn(1'b0, 1'b0, 32'h0, 32'h0, ta, tr, rd);
    chk("fetch_data",    rd,      32'h4422_1802);
    chk("fetch_latency", tr - ta, LAT + 1);

    // Store then load at address 8
    w0 = wr_count;
    do_txn(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, ta, tr, rd);
    chk("store_rsp_zero",  rd,            32'h0);
    chk("store_one_write", wr_count - w0, 1);
    chk("store_mem",       mem[2],        32'hDEAD_BEEF);
    do_txn(1'b1, 1'b0, 32'h8, 32'h0, ta, tr, rd);
    chk("load_data",       rd,            32'hDEAD_BEEF);

    // Simultaneous requests: fetch to 4, load from 12
    fetchReq = 1'b1; fetchAddr = 32'h4;
    dataReq = 1'b1; dataWe = 1'b0; dataAddr = 32'hC;
    @(negedge clk);
    chk("simul_first", {fetchReady, dataReady}, RR ? 2'b10 : 2'b01);
    ta = cyc;
    tick();
    if (RR) fetchReq = 1'b0;
    else dataReq = 1'b0;
    got = 1'b0;
    tb  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (RR ? dataReady : fetchReady) begin
        got = 1'b1;
        tb  = cyc;
      end
    end
    chk("simul_loser_seen", got,     1'b1);
    chk("simul_loser_wait", tb - ta, LAT + 2);
    tick();
    fetchReq = 1'b0;
    dataReq  = 1'b0;
    repeat (LAT + 2) tick();
    chk("simul_fetch_rsp", fetchRspData, 32'h1000_0101);
    chk("simul_data_rsp",  dataRspData,  32'h1000_0303);

    // Back-to-back fetches with request held
    fetchReq = 1'b1; fetchAddr = 32'h10;
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 3; i++) begin
      @(negedge clk);
      if (fetchReady) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_gap0", acc_t[1] - acc_t[0], LAT + 2);
    chk("b2b_gap1", acc_t[2] - acc_t[1], LAT + 2);
    tick();
    fetchReq = 1'b0;
    repeat (LAT + 2) tick();
    chk("b2b_data", fetchRspData, 32'h1000_0404);

    // Reset in the middle of a store, before its write cycle
    dataReq = 1'b1; dataWe = 1'b1; dataAddr = 32'hC; dataWdata = 32'h1234_5678;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dataReady;
    end
    chk("abort_accept_seen", got, 1'b1);
    tick();
    dataReq = 1'b0;
    w0 = wr_count;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_we",      memWriteEnable, 1'b0);
    chk("abort_busy",    busy,           1'b0);
    chk("abort_addr",    memAddress,     32'h0);
    chk("abort_drspv",   dataRspValid,   1'b0);
    chk("abort_drsp",    dataRspData,    32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (LAT + 2) tick();
    chk("abort_no_write", wr_count - w0, 0);
    chk("abort_mem",      mem[3],        32'h1000_0303);

    // Recovery after reset
    do_txn(1'b0, 1'b0, 32'hC, 32'h0, ta, tr, rd);
    chk("recover_fetch", rd, 32'h1000_0303);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
